mips_data_mem: RTL

Byte-addressed data memory that serves as the responder end of the `mips_core` load/store port. It answers the core's `mem_addr`, `mem_data_in` and `mem_write_en` with combinational read data on `mem_data_out`, and it commits writes on the clock edge. After every reset it zero-fills itself with a sweep state machine and raises `busy` while the sweep runs. It sits beside the instruction memory in the top-level testbench and SoC wrapper.

---
 rtl/mips_data_mem_pkg.sv | 14 +
 rtl/mips_data_mem_if.sv | 30 +++
 rtl/mips_data_mem_clear_fsm.sv | 52 +++++
 rtl/mips_data_mem.sv | 91 +++++++++
 4 files changed

// File: rtl/mips_data_mem_pkg.sv
// Shared types for the mips_core load/store port and the data memory behind it.
package mips_mem_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [0:3] word_bytes_t;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_t;

   localparam int unsigned LANES = 4;

endpackage

// File: rtl/mips_data_mem_if.sv
// Load/store bus between mips_core (master) and mips_data_mem (slave).
interface mips_data_mem_if;
   import mips_mem_pkg::*;

   logic [31:0] mem_addr;
   word_bytes_t mem_data_in;
   logic        mem_write_en;
   word_bytes_t mem_data_out;
   logic        busy;
   logic        addr_err;

   modport master (
      output mem_addr,
      output mem_data_in,
      output mem_write_en,
      input  mem_data_out,
      input  busy,
      input  addr_err
   );

   modport slave (
      input  mem_addr,
      input  mem_data_in,
      input  mem_write_en,
      output mem_data_out,
      output busy,
      output addr_err
   );

endinterface

// File: rtl/mips_data_mem_clear_fsm.sv
// Post-reset zero-fill sequencer: walks every word once, then parks in READY.
module mem_clear_fsm
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_b,
   output logic [ADDR_WIDTH-3:0] o_clr_idx,
   output logic                  o_clr_we,
   output mem_state_t            o_state,
   output logic                  o_busy
);

   localparam logic [ADDR_WIDTH-3:0] LAST_WORD = '1;

   mem_state_t            r_state;
   logic [ADDR_WIDTH-3:0] r_clr_cnt;
   logic                  r_busy;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state   <= CLEAR;
         r_clr_cnt <= '0;
         r_busy    <= 1'b1;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (r_clr_cnt == LAST_WORD) begin
                  r_state <= READY;
                  r_busy  <= 1'b0;
               end
            end
            READY: begin
               r_state <= READY;
            end
            default: begin
               r_state   <= CLEAR;
               r_clr_cnt <= '0;
               r_busy    <= 1'b1;
            end
         endcase
      end
   end

   assign o_clr_idx = r_clr_cnt;
   assign o_clr_we  = (r_state == CLEAR);
   assign o_state   = r_state;
   assign o_busy    = r_busy;

endmodule

// File: rtl/mips_data_mem.sv
// Byte-addressed data memory: combinational 4-lane reads, edge-committed writes,
// zero-filled by mem_clear_fsm after every reset.
module mips_data_mem
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst_b,
   mips_data_mem_if.slave  bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   byte_t                 r_mem [DEPTH];

   logic [ADDR_WIDTH-3:0] w_clr_idx;
   logic                  w_clr_we;
   mem_state_t            w_state;
   logic                  w_busy;
   logic                  w_addr_err;
   logic                  w_core_we;
   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_lane_addr [LANES];
   logic [ADDR_WIDTH-1:0] w_wr_addr   [LANES];
   byte_t                 w_wr_data   [LANES];
   word_bytes_t           w_rdata;

   mem_clear_fsm #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_clear_fsm (
      .clk       (clk),
      .rst_b     (rst_b),
      .o_clr_idx (w_clr_idx),
      .o_clr_we  (w_clr_we),
      .o_state   (w_state),
      .o_busy    (w_busy)
   );

   generate
      if (ADDR_WIDTH < 32) begin : g_err
         assign w_addr_err = |bus.mem_addr[31:ADDR_WIDTH];
      end else begin : g_no_err
         assign w_addr_err = 1'b0;
      end
   endgenerate

   // Lane addresses are truncated to ADDR_WIDTH bits so the top lanes wrap to byte 0.
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         w_lane_addr[i] = bus.mem_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
      end
   end

   assign w_core_we = (w_state == READY) && bus.mem_write_en && !w_addr_err;
   assign w_wr_en   = w_clr_we || w_core_we;

   // The sweep owns the write port in CLEAR; core stores are dropped, not held.
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         w_wr_addr[i] = w_lane_addr[i];
         w_wr_data[i] = bus.mem_data_in[i];
         if (w_clr_we) begin
            w_wr_addr[i] = {w_clr_idx, 2'(i)};
            w_wr_data[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            r_mem[w_wr_addr[i]] <= w_wr_data[i];
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if ((w_state == READY) && !w_addr_err) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            w_rdata[i] = r_mem[w_lane_addr[i]];
         end
      end
   end

   assign bus.mem_data_out = w_rdata;
   assign bus.busy         = w_busy;
   assign bus.addr_err     = w_addr_err;

endmodule
